seq_detect_param: RTL
=====================

# seq_detect_param

Parametrised serial bit-pattern detector for single-bit input streams. It replaces fixed-pattern hard-coded sequence FSMs in the FSM block family. Pattern length and reset-default pattern are parameters, and the pattern can be reloaded at runtime. Overlapping or non-overlapping detection is selected at runtime. Input is qualified by a valid strobe, and a saturating match counter is provided for observability.

## Interface
- `PAT_LEN`, default 4: pattern length in bits. Legal range is 2..32.
- `PATTERN`, default 4'b1100: reset-default pattern, width PAT_LEN. The MSB is the first bit received.
- `COUNT_W`, default 8: width of the match counter.

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dn`  in  1  serial data bit.
- `din_valid`  in  1  `dn` is sampled only when this is high.
- `overlap`  in  1  1 selects overlapping detection; 0 selects non-overlapping.
- `pat_load`  in  1  load `pat_in` into the pattern register this cycle.
- `pat_in`  in  PAT_LEN  new pattern, MSB first.
- `cnt_clr`  in  1  clear `match_count`.
- `y`  out  1  one-cycle match pulse.
- `match_count`  out  COUNT_W  number of matches since reset or clear; saturates.

## Operation
- **Internal state:**
  - `pat_reg` (PAT_LEN bits).
  - History shift register `hist` (PAT_LEN bits, newest bit in the LSB).
  - Fill counter `fill` (width $clog2(PAT_LEN+1)), range 0..PAT_LEN.
- **Reset** (`rst`=1 at an edge), regardless of any other input:
  - `pat_reg` = PATTERN, `hist` = 0, `fill` = 0.
  - `y` = 0, `match_count` = 0.
- **Priority per edge** when `rst`=0:
  - `pat_load` is checked first, then `din_valid`.
  - `cnt_clr` is evaluated independently on the counter.
- **Pattern load** (`pat_load`=1):
  - `pat_reg` <= `pat_in`, `fill` <= 0, `y` <= 0.
  - `dn` is ignored that cycle even if `din_valid`=1.
  - `hist` is unchanged, but it is not trusted until `fill` refills.
- **Sample** (`pat_load`=0, `din_valid`=1):
  - `hist_n` = {`hist`[PAT_LEN-2:0], `dn`}; `hist` <= `hist_n`.
  - `fill_n` = min(`fill`+1, PAT_LEN).
  - `hit` = (`fill_n` == PAT_LEN) && (`hist_n` == `pat_reg`).
  - `y` <= `hit`.
  - If `hit` and `overlap`=0: `fill` <= 0. This means the next match needs PAT_LEN fresh bits.
  - Otherwise: `fill` <= `fill_n`.
- **Idle** (`pat_load`=0, `din_valid`=0):
  - `y` <= 0.
  - `hist` and `fill` hold.
  - Gaps in `din_valid` are transparent to detection.
- **Counter:**
  - If `cnt_clr`: `match_count` <= 0. Clear wins over a simultaneous `hit`; that match is not counted but `y` still pulses.
  - Else if `hit` and `match_count` != all-ones: increment.
  - At all-ones the counter holds.
- **Mode changes:** `overlap` is sampled on the same edge as the bit that completes a match. Changing it mid-stream affects only subsequent hits.

## Timing
- **Latency:** `y` rises on the edge that samples the last pattern bit and is high for exactly one cycle. With continuous `din_valid`, back-to-back hits produce `y` high on consecutive cycles.
- **Counter timing:** `match_count` updates on the same edge as `y`.
- **Minimum gap between hits:**
  - Overlapping mode: 1 valid bit.
  - Non-overlapping mode: PAT_LEN valid bits.
- **First possible hit:** PAT_LEN valid samples after reset or after `pat_load`.
- **Mid-operation reset:** all partial progress is discarded. A pattern straddling the reset edge does not match.
- No combinational path exists from any input to any output.

## Test plan
- **Default pattern, single match:** defaults, `overlap`=1, stream 1,1,0,0 with `din_valid`=1.
  - `y`=1 only on the cycle after the 4th sample; `match_count`=1.
  - Stream 0,1,1,1,0,0 gives exactly one hit.
- **Overlap vs non-overlap:** load `pat_in`=1010, then stream 1,0,1,0,1,0.
  - `overlap`=1: two `y` pulses (after bits 4 and 6); `match_count`=2.
  - `overlap`=0: one pulse; `match_count`=1.
- **Valid gaps:** stream 1,1,0,0 with `din_valid` low for 3 cycles between each bit.
  - One hit, coincident with the 4th valid sample; `y`=0 during gaps.
- **Reset and load mid-stream:**
  - Send 1,1,0, assert `rst`, then send 0: no hit.
  - Send 1,1,0, assert `pat_load` (`pat_in`=1100) with `din_valid`=1 and `dn`=0, then send 0: no hit, and `pat_reg`=1100.
- **Counter saturation and clear:** `COUNT_W`=2, `overlap`=1, pattern 1100, five back-to-back 1100 groups.
  - `match_count` reads 1,2,3,3,3.
  - Assert `cnt_clr` on a hit cycle: `match_count`=0 while `y`=1.
- **Width sweep:** `PAT_LEN`=2 (`PATTERN`=11) and `PAT_LEN`=8 (`PATTERN`=8'hA5).
  - PAT_LEN=2, `overlap`=1, stream 1,1,1: 2 hits.
  - PAT_LEN=8: a random 1000-bit stream matches a reference-model hit count for both `overlap` modes.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param
// Serial bit-pattern detector with a runtime-reloadable pattern, selectable
// overlapping / non-overlapping detection and a saturating match counter.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   dn           serial data bit, sampled when din_valid is high
//   din_valid    qualifies dn
//   overlap      1 = overlapping detection, 0 = non-overlapping
//   pat_load     load pat_in into the pattern register (takes priority over dn)
//   pat_in       new pattern, MSB is the first bit received
//   cnt_clr      clear match_count (wins over a simultaneous hit)
//   y            registered one-cycle match pulse
//   match_count  saturating count of matches since reset / clear
module seq_detect_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1100,
    parameter int                 COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dn,
    input  logic               din_valid,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               cnt_clr,
    output logic               y,
    output logic [COUNT_W-1:0] match_count
);

    localparam int                FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] pat_reg;
    logic [PAT_LEN-1:0] hist;
    logic [FILL_W-1:0]  fill;

    logic [PAT_LEN-1:0] hist_n;
    logic [FILL_W-1:0]  fill_n;
    logic               hit;

    // fill counts bits received since the last restart (reset, load or a
    // non-overlapping hit); hist is only trusted once fill reaches PAT_LEN.
    always_comb begin
        hist_n = {hist[PAT_LEN-2:0], dn};
        fill_n = (fill == FULL) ? fill : fill + FILL_W'(1);
        hit    = !pat_load && din_valid && (fill_n == FULL) && (hist_n == pat_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_reg <= PATTERN;
            hist    <= '0;
            fill    <= '0;
            y       <= 1'b0;
        end else if (pat_load) begin
            pat_reg <= pat_in;
            fill    <= '0;
            y       <= 1'b0;
        end else if (din_valid) begin
            hist <= hist_n;
            y    <= hit;
            // Non-overlapping: the next match must be built from fresh bits.
            fill <= (hit && !overlap) ? '0 : fill_n;
        end else begin
            y <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clr)
            match_count <= '0;
        else if (hit && (match_count != '1))
            match_count <= match_count + COUNT_W'(1);
    end

endmodule
